// File: rtl/alu_ctrl_mula.sv
// EX-stage ALU control decode with a multi-cycle multiply-accumulate (MULA) engine.
// Optional build macro ALU_CTRL_SIGNED_MULA_EN selects two's-complement MULA operands.
//
// state  | meaning
// IDLE   | no MULA in flight; decode flows freely
// MUL    | shift-add multiply, MUL_STEP multiplier bits per cycle, pipeline stalled
// ACC    | add product low half into accumulator, MulaDone high
module alu_ctrl_mula #(
    parameter int DATA_W   = 32,
    parameter int MUL_STEP = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              InValid,
    input  logic [3:0]        ALUop,
    input  logic [5:0]        FuncCode,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic              Flush,
    input  logic              AccClr,
    output logic [3:0]        ALUCtrl,
    output logic              CtrlValid,
    output logic              IllegalFunc,
    output logic              Stall,
    output logic              MulaBusy,
    output logic              MulaDone,
    output logic [DATA_W-1:0] AccOut
);

    localparam int N     = DATA_W / MUL_STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * DATA_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] acc_q, acc_d;

    logic [3:0]        ctrl_q;
    logic              vld_q;
    logic              ill_q;

    logic [3:0]        dec_ctrl;
    logic              dec_ill;
    logic              mula_req;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              neg_in;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     prod_fin;
    logic              prod_hi_unused;

    always_comb begin
        dec_ctrl = ALUop;
        dec_ill  = 1'b0;
        if (ALUop == 4'b1111) begin
            case (FuncCode)
                6'b000000: dec_ctrl = 4'b0011;
                6'b000010: dec_ctrl = 4'b0100;
                6'b000011: dec_ctrl = 4'b1101;
                6'b100000: dec_ctrl = 4'b0010;
                6'b100001: dec_ctrl = 4'b1000;
                6'b100010: dec_ctrl = 4'b0110;
                6'b100011: dec_ctrl = 4'b1001;
                6'b100100: dec_ctrl = 4'b0000;
                6'b100101: dec_ctrl = 4'b0001;
                6'b100110: dec_ctrl = 4'b1010;
                6'b100111: dec_ctrl = 4'b1100;
                6'b101010: dec_ctrl = 4'b0111;
                6'b101011: dec_ctrl = 4'b1011;
                6'b111000: dec_ctrl = 4'b0010;
                default: begin
                    dec_ctrl = 4'b0010;
                    dec_ill  = 1'b1;
                end
            endcase
        end
    end

    assign mula_req = InValid && (ALUop == 4'b1111) && (FuncCode == 6'b111000)
                      && (state_q == S_IDLE);
    assign Stall    = mula_req || (state_q == S_MUL);
    assign MulaBusy = (state_q != S_IDLE);
    assign MulaDone = (state_q == S_ACC);

`ifdef ALU_CTRL_SIGNED_MULA_EN
    // Multiply magnitudes; the sign is reapplied to the full product in ACC.
    assign a_mag  = OpA[DATA_W-1] ? -OpA : OpA;
    assign b_mag  = OpB[DATA_W-1] ? -OpB : OpB;
    assign neg_in = OpA[DATA_W-1] ^ OpB[DATA_W-1];
`else
    assign a_mag  = OpA;
    assign b_mag  = OpB;
    assign neg_in = 1'b0;
`endif

    assign prod_fin = neg_q ? -prod_q : prod_q;
    // Only the low half accumulates; the high half is kept for full-width product.
    assign prod_hi_unused = ^prod_fin[PW-1:DATA_W];

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) pp = pp + (mcand_q << i);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        if (AccClr) acc_d = '0;
        case (state_q)
            S_IDLE: begin
                if (mula_req && !Flush) begin
                    state_d  = S_MUL;
                    mcand_d  = {{DATA_W{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    prod_d   = '0;
                    cnt_d    = '0;
                    neg_d    = neg_in;
                end
            end
            S_MUL: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d   = prod_q + pp;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d   = (AccClr ? '0 : acc_q) + prod_fin[DATA_W-1:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ctrl_q <= 4'b0000;
            vld_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            ill_q <= 1'b0;
            if (!Stall) begin
                if (InValid) begin
                    ctrl_q <= dec_ctrl;
                    vld_q  <= 1'b1;
                    ill_q  <= dec_ill;
                end else begin
                    vld_q <= 1'b0;
                end
            end
        end
    end

    assign ALUCtrl     = ctrl_q;
    assign CtrlValid   = vld_q;
    assign IllegalFunc = ill_q;
    assign AccOut      = acc_q;

endmodule
